ifetch: RTL
===========

# ifetch

Instruction fetch stage sitting directly upstream of the `proc` decode/execute datapath. It fetches 32-bit words from instruction memory over a valid/ack handshake and splits them into 16-bit instructions. Instructions are buffered in a small prefetch FIFO and presented to decode with their PC over a valid/ready handshake. A taken branch from execute redirects fetch, flushes the buffer and discards any in-flight memory response.

## Interface
- `DEPTH`, 4 — FIFO depth in 16-bit instructions; power of two, ≥ 2.
- `RESET_PC`, 32'h0 — first instruction address; halfword aligned.

- `i_clk`  in  1  — clock; all state on rising edge.
- `i_rst`  in  1  — reset, asynchronous, active-low.
- `o_mem_req`  out  1  — memory request valid.
- `o_mem_addr`  out  32  — word address, bits [1:0] always 0.
- `i_mem_ack`  in  1  — response valid this cycle; `i_mem_data` sampled at the same edge.
- `i_mem_data`  in  32  — [15:0] = halfword at addr, [31:16] = halfword at addr+2.
- `o_ir`  out  16  — instruction at FIFO head.
- `o_ir_pc`  out  32  — PC of `o_ir`.
- `o_ir_valid`  out  1  — `o_ir` / `o_ir_pc` valid.
- `i_ir_ready`  in  1  — decode accepts; pop when valid & ready.
- `i_jump`  in  1  — redirect request, one cycle.
- `i_jump_pc`  in  32  — redirect target; bit 0 ignored.

## Operation
- Registers:
  - `fpc` — fetch halfword address.
  - `hpc` — head PC.
  - FIFO storage, read/write pointers, count.
  - state ∈ {IDLE, REQ, DISCARD}.
- `o_mem_req` = (state ≠ IDLE).
- `o_mem_addr` = {fpc[31:2], 2'b00}; held stable while the request is pending.
- IDLE → REQ when free slots ≥ 2 and no `i_jump`.
- REQ + ack, no jump:
  - If fpc[1] = 0, push [15:0] then [31:16].
  - If fpc[1] = 1, push [31:16] only.
  - fpc ← {fpc[31:2] + 1, 2'b00}.
  - → IDLE.
- Only one request is ever outstanding. The free-slot check at issue guarantees no overflow.
- `i_jump`, any state:
  - Flush FIFO (count 0, `o_ir_valid` low next cycle).
  - fpc ← hpc ← {i_jump_pc[31:1], 1'b0}.
- Jump in REQ without ack → DISCARD. Request stays asserted with the **old** address until ack; the response is dropped, then → IDLE.
- Jump in REQ or DISCARD coinciding with ack: data dropped → IDLE.
- Jump in IDLE: stays IDLE.
- Pop:
  - hpc ← hpc + 2.
  - The FIFO head is first-word-fall-through: `o_ir` comes from storage, not registered.
- Jump and pop in the same cycle: jump wins; pop and hpc increment are ignored.
- Push and pop in the same cycle: both occur; count changes by pushes − 1.
- Pointers wrap modulo DEPTH.
- `o_ir_pc` = hpc (32-bit, wraps at 2^32).
- Empty: `o_ir_valid` = 0.

## Timing
- Reset values:
  - state IDLE, `o_mem_req` 0.
  - `o_mem_addr` = {RESET_PC[31:2], 2'b00}.
  - fpc = hpc = {RESET_PC[31:1], 0}, so `o_ir_pc` = hpc.
  - `o_ir_valid` 0, `o_ir` 16'h0 (storage cleared).
- After reset release:
  - Edge 1: `o_mem_req` high.
  - If `i_mem_ack` is high in that cycle, `o_ir_valid` is high from edge 2.
  - Fetch-to-decode latency is therefore 1 cycle after ack.
- Sustained throughput: 2 instructions per ack. There is one idle (IDLE) cycle between consecutive requests.
- Redirect: new-target request issues at earliest 1 edge after jump from IDLE, or 1 edge after the stale ack is absorbed.
- Reset asserted mid-request: immediate return to reset values; any later ack is ignored while in IDLE.

## Configuration
- `IFETCH_PERF_EN`:
  - Defined: adds output `o_stall_cnt` [31:0], reset 0. It increments each cycle `o_ir_valid` = 0, saturating at 32'hFFFF_FFFF.
  - Undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset, RESET_PC = 0, ack every request, ready = 1 → `o_ir_pc` sequence 0, 2, 4, 6…; `o_ir` matches halfwords of words at 0, 4, …; first valid at edge 2.
- RESET_PC = 32'h6 → first request addr 4; only [31:16] pushed; first `o_ir_pc` = 6, then 8.
- ready = 0, DEPTH = 4, ack always → exactly 2 acks absorbed, FIFO full, no further `o_mem_req`; raise ready → fetch resumes when 2 slots are free.
- Jump to 32'h100 while in REQ with ack delayed 3 cycles → addr unchanged until ack, data dropped, next request addr 32'h100; first `o_ir_pc` = 32'h100.
- Jump coincident with pop and ack → FIFO empty next cycle, hpc = target, no entries from that ack appear.
- `IFETCH_PERF_EN` defined, ack withheld 5 cycles after reset → `o_stall_cnt` ≥ 6 when first valid appears; reset mid-count → 0.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch: 32-bit memory words split into 16-bit instructions, buffered in a FWFT
// prefetch FIFO and presented to decode with their PC. Optional stall counter: IFETCH_PERF_EN.
module ifetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  output logic [15:0] o_ir,
  output logic [31:0] o_ir_pc,
  output logic        o_ir_valid,
  input  logic        i_ir_ready,
`ifdef IFETCH_PERF_EN
  output logic [31:0] o_stall_cnt,
`endif
  input  logic        i_jump,
  input  logic [31:0] i_jump_pc
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  localparam logic [31:0] RESET_HPC = {RESET_PC[31:1], 1'b0};

  state_t      state;
  logic [31:0] fpc;
  logic [31:0] hpc;
  logic [31:0] addr_q;
  logic [15:0] mem [DEPTH];
  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  cnt_t        count;

  logic [31:0] jump_target;
  logic        can_issue;
  logic        accept;
  logic        pop;
  cnt_t        n_push;
  logic [15:0] first_hw;
  cnt_t        count_nxt;

  assign jump_target = {i_jump_pc[31:1], 1'b0};
  // Two free slots at issue time means any response fits, so the FIFO can never overflow.
  assign can_issue   = (cnt_t'(DEPTH) - count) >= cnt_t'(2);
  assign accept      = (state == REQ) && i_mem_ack && !i_jump;
  assign pop         = o_ir_valid && i_ir_ready && !i_jump;
  assign n_push      = accept ? (fpc[1] ? cnt_t'(1) : cnt_t'(2)) : cnt_t'(0);
  assign first_hw    = fpc[1] ? i_mem_data[31:16] : i_mem_data[15:0];
  assign count_nxt   = count + n_push - cnt_t'(pop);

  // While a request is pending the address comes from addr_q, so a redirect that
  // rewrites fpc cannot disturb the request still owed a response.
  assign o_mem_req  = (state != IDLE);
  assign o_mem_addr = (state == IDLE) ? {fpc[31:2], 2'b00} : addr_q;
  assign o_ir       = mem[rd_ptr];
  assign o_ir_pc    = hpc;
  assign o_ir_valid = (count != '0);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state  <= IDLE;
      fpc    <= RESET_HPC;
      hpc    <= RESET_HPC;
      addr_q <= {RESET_PC[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset so o_ir reads a defined 16'h0 out of reset; fine at this small depth.
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (!i_jump && can_issue) begin
            state  <= REQ;
            addr_q <= {fpc[31:2], 2'b00};
          end
        end
        REQ: begin
          if (i_mem_ack)   state <= IDLE;
          else if (i_jump) state <= DISCARD;
        end
        DISCARD: begin
          if (i_mem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (i_jump) begin
        fpc    <= jump_target;
        hpc    <= jump_target;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) begin
          mem[wr_ptr] <= first_hw;
          if (!fpc[1]) mem[wr_ptr + ptr_t'(1)] <= i_mem_data[31:16];
          wr_ptr <= wr_ptr + ptr_t'(n_push);
          fpc    <= {fpc[31:2] + 30'd1, 2'b00};
        end
        if (pop) begin
          rd_ptr <= rd_ptr + ptr_t'(1);
          hpc    <= hpc + 32'd2;
        end
        count <= count_nxt;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_stall_cnt <= '0;
    end else if (!o_ir_valid && (o_stall_cnt != 32'hFFFF_FFFF)) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
